uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 10 +
 rtl/uart_rx_fifo_if.sv | 33 +++
 rtl/uart_rx_fifo_sync_fifo.sv | 50 +++++
 rtl/uart_rx_fifo.sv | 63 ++++++
 tb/tb_uart_rx_fifo.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path constants.
// Used by the RX FIFO and by the UART top level.
package uart_rx_fifo_pkg;

    localparam int UART_FIFO_DEPTH = 8;
    localparam int UART_FIFO_AW    = $clog2(UART_FIFO_DEPTH);

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and host-side signals of the UART RX FIFO.
// master drives the FIFO inputs, slave is the FIFO itself.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
);

    uart_byte_t    rx_data;
    logic          ctrl_in_rx_contains_data;
    logic          ctrl_out_rx_contains_data;
    logic          rd_en;
    uart_byte_t    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          overrun_clr;

    modport master (
        output rx_data, ctrl_in_rx_contains_data, rd_en, overrun_clr,
        input  ctrl_out_rx_contains_data, rd_data, empty, full, count,
        input  overrun
    );

    modport slave (
        input  rx_data, ctrl_in_rx_contains_data, rd_en, overrun_clr,
        output ctrl_out_rx_contains_data, rd_data, empty, full, count,
        output overrun
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// DEPTH x 8 first-word-fall-through FIFO: storage, pointers, count.
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  uart_byte_t  wr_data,
    input  logic        pop,
    output uart_byte_t  rd_data,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full
);

    uart_byte_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage is not reset; only pointers and count are.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX FIFO: receiver flag handshake and sticky overrun around sync_fifo.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);

    logic push;
    logic pop;
    logic full;
    logic empty;
    logic flag_q;
    logic full_q;
    logic overrun_set;

    assign push = bus.ctrl_in_rx_contains_data & ~full;
    assign pop  = bus.rd_en & ~empty;

    // Holding the flag while full keeps the byte until a slot frees.
    assign bus.ctrl_out_rx_contains_data = bus.ctrl_in_rx_contains_data & full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (bus.rx_data),
        .pop     (pop),
        .rd_data (bus.rd_data),
        .count   (bus.count),
        .empty   (empty),
        .full    (full)
    );

    assign bus.empty = empty;
    assign bus.full  = full;

    // A held byte vanishing while full means the receiver overwrote it.
    assign overrun_set = flag_q & ~bus.ctrl_in_rx_contains_data & full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q      <= 1'b0;
            full_q      <= 1'b0;
            bus.overrun <= 1'b0;
        end else begin
            flag_q <= bus.ctrl_in_rx_contains_data;
            full_q <= full;
            if (overrun_set)
                bus.overrun <= 1'b1;
            else if (bus.overrun_clr)
                bus.overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rx_data = base + 8'(i);
            bus.ctrl_in_rx_contains_data = 1'b1;
            step();
        end
    endtask

    initial begin
        bus.rx_data = '0;
        bus.ctrl_in_rx_contains_data = 1'b0;
        bus.rd_en = 1'b0;
        bus.overrun_clr = 1'b0;
        #12;
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_ctrl_out", 32'(bus.ctrl_out_rx_contains_data), 0);
        check("rst_overrun", 32'(bus.overrun), 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // single byte
        bus.rx_data = 8'hA5;
        bus.ctrl_in_rx_contains_data = 1'b1;
        step();
        bus.ctrl_in_rx_contains_data = 1'b0;
        check("single_empty", 32'(bus.empty), 0);
        check("single_count", 32'(bus.count), 1);
        check("single_data", 32'(bus.rd_data), 32'hA5);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("single_pop_empty", 32'(bus.empty), 1);

        // ordering
        fill(8'h00);
        bus.ctrl_in_rx_contains_data = 1'b0;
        check("order_full", 32'(bus.full), 1);
        check("order_count", 32'(bus.count), 8);
        for (int i = 0; i < DEPTH; i++) begin
            check("order_data", 32'(bus.rd_data), i);
            bus.rd_en = 1'b1;
            step();
        end
        bus.rd_en = 1'b0;
        check("order_empty", 32'(bus.empty), 1);

        // full hold
        fill(8'h80);
        bus.rx_data = 8'h3C;
        check("hold_ctrl_out", 32'(bus.ctrl_out_rx_contains_data), 1);
        step();
        check("hold_count", 32'(bus.count), 8);
        check("hold_ctrl_out2", 32'(bus.ctrl_out_rx_contains_data), 1);
        check("hold_head", 32'(bus.rd_data), 32'h80);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        check("hold_pop_count", 32'(bus.count), 7);
        check("hold_pop_ctrl_out", 32'(bus.ctrl_out_rx_contains_data), 0);
        step();
        bus.ctrl_in_rx_contains_data = 1'b0;
        check("hold_push_count", 32'(bus.count), 8);
        for (int i = 1; i < DEPTH; i++) begin
            check("hold_drain", 32'(bus.rd_data), 32'h80 + i);
            bus.rd_en = 1'b1;
            step();
        end
        check("hold_drain_last", 32'(bus.rd_data), 32'h3C);
        step();
        bus.rd_en = 1'b0;
        check("hold_drain_empty", 32'(bus.empty), 1);
        check("hold_no_overrun", 32'(bus.overrun), 0);

        // overrun
        fill(8'h40);
        bus.rx_data = 8'h55;
        step();
        check("ovr_before", 32'(bus.overrun), 0);
        bus.ctrl_in_rx_contains_data = 1'b0;
        step();
        check("ovr_set", 32'(bus.overrun), 1);
        check("ovr_count", 32'(bus.count), 8);
        step();
        check("ovr_sticky", 32'(bus.overrun), 1);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        check("ovr_clr", 32'(bus.overrun), 0);
        bus.rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        bus.rd_en = 1'b0;
        check("ovr_drain_empty", 32'(bus.empty), 1);

        // wrap-around
        for (int i = 0; i < 20; i++) begin
            bus.rx_data = 8'(i);
            bus.ctrl_in_rx_contains_data = 1'b1;
            step();
            bus.ctrl_in_rx_contains_data = 1'b0;
            check("wrap_count1", 32'(bus.count), 1);
            check("wrap_data", 32'(bus.rd_data), i);
            bus.rd_en = 1'b1;
            step();
            bus.rd_en = 1'b0;
            check("wrap_count0", 32'(bus.count), 0);
        end

        // reset mid-stream
        for (int i = 0; i < 5; i++) begin
            bus.rx_data = 8'h20 + 8'(i);
            bus.ctrl_in_rx_contains_data = 1'b1;
            step();
        end
        bus.ctrl_in_rx_contains_data = 1'b0;
        check("mid_count5", 32'(bus.count), 5);
        reset = 1'b1;
        #1;
        check("mid_rst_empty", 32'(bus.empty), 1);
        check("mid_rst_count", 32'(bus.count), 0);
        step();
        reset = 1'b0;
        bus.rx_data = 8'h11;
        bus.ctrl_in_rx_contains_data = 1'b1;
        step();
        bus.ctrl_in_rx_contains_data = 1'b0;
        check("mid_post_count", 32'(bus.count), 1);
        check("mid_post_data", 32'(bus.rd_data), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
